// File: rtl/fsic_wb_pkg.sv
// Shared types and defaults for the FSIC Wishbone command sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fsic_wb_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int SEL_W     = DATA_W / 8;
    localparam int CMD_DEPTH = 4;
    localparam int GAP       = 6;
    localparam int TIMEOUT   = 255;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_REQ  = 2'd1,
        WB_RSP  = 2'd2,
        WB_GAP  = 2'd3
    } wb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  sel;
        logic              we;
    } wb_cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } wb_rsp_t;

endpackage

// File: rtl/fsic_wb_cmd_seq_if.sv
// Command stream, response stream and Wishbone master bus of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: cmd_ready / rsp_ready valid-ready pairs; Wishbone uses ack.
interface fsic_wb_cmd_seq_if
    import fsic_wb_pkg::*;
;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_adr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [SEL_W-1:0]  cmd_sel;
    logic              cmd_we;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] wbs_adr;
    logic [DATA_W-1:0] wbs_wdata;
    logic [SEL_W-1:0]  wbs_sel;
    logic              wbs_cyc;
    logic              wbs_stb;
    logic              wbs_we;
    logic              wbs_ack;
    logic [DATA_W-1:0] wbs_rdata;

    // Sequencer side: consumes commands, produces responses, masters Wishbone.
    modport master (
        input  cmd_valid, cmd_adr, cmd_wdata, cmd_sel, cmd_we, rsp_ready, wbs_ack, wbs_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we
    );

    // Environment side: command source, response sink, Wishbone slave.
    modport slave (
        output cmd_valid, cmd_adr, cmd_wdata, cmd_sel, cmd_we, rsp_ready, wbs_ack, wbs_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we
    );

endinterface

// File: rtl/fsic_wb_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO of wb_cmd_t.
// Latency: a push is visible on pop_dat/empty the cycle after the pushing edge.
// Backpressure: push ignored while full (even if popping); pop ignored while empty.
module fsic_wb_cmd_fifo
    import fsic_wb_pkg::*;
#(
    parameter int pDEPTH = CMD_DEPTH
) (
    input  logic    coreclk,
    input  logic    wb_rst,
    input  logic    push,
    input  wb_cmd_t push_dat,
    input  logic    pop,
    output wb_cmd_t pop_dat,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(pDEPTH);

    wb_cmd_t       mem [pDEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    // Pointers wrap naturally; reset flushes by equalising them.
    always_ff @(posedge coreclk or negedge wb_rst) begin
        if (!wb_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; contents are only read behind the pointers.
    always_ff @(posedge coreclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/fsic_wb_cmd_seq.sv
// Buffers register commands and issues one single-beat Wishbone cycle each, returning one response.
// Latency: command accepted into an empty FIFO at edge E0 drives cyc/stb after E0+1; response after ack edge.
// Backpressure: cmd_ready = FIFO not full; FSM holds in RSP until rsp_ready. Optional FSIC_WB_TIMEOUT_EN aborts stuck cycles.
module fsic_wb_cmd_seq
    import fsic_wb_pkg::*;
#(
    parameter int pADDR_WIDTH = ADDR_W,
    parameter int pDATA_WIDTH = DATA_W,
    parameter int pCMD_DEPTH  = CMD_DEPTH,
    parameter int pGAP        = GAP,
    parameter int pTIMEOUT    = TIMEOUT
) (
    input  logic                    coreclk,
    input  logic                    wb_rst,
    fsic_wb_cmd_seq_if.master       bus,
    output logic                    busy
);

    localparam logic [1:0] ST_IDLE = WB_IDLE;
    localparam logic [1:0] ST_REQ  = WB_REQ;
    localparam logic [1:0] ST_RSP  = WB_RSP;
    localparam logic [1:0] ST_GAP  = WB_GAP;
    localparam int         GW      = (pGAP > 1) ? $clog2(pGAP) : 1;

    logic [1:0]               state;
    logic [GW-1:0]            gap_cnt;
    wb_cmd_t                  push_dat;
    wb_cmd_t                  head;
    logic                     full;
    logic                     empty;
    logic                     pop;
    logic                     to_hit;
    logic                     req_end;

    logic [pADDR_WIDTH-1:0]   adr_q;
    logic [pDATA_WIDTH-1:0]   wdata_q;
    logic [pDATA_WIDTH/8-1:0] sel_q;
    logic                     we_q;
    logic                     act_q;
    logic                     rsp_valid_q;
    logic [pDATA_WIDTH-1:0]   rsp_rdata_q;
    logic                     rsp_err_q;

    assign push_dat      = '{adr: bus.cmd_adr, wdata: bus.cmd_wdata, sel: bus.cmd_sel, we: bus.cmd_we};
    assign bus.cmd_ready = !full;
    assign pop           = (state == ST_IDLE) && !empty;
    assign req_end       = (state == ST_REQ) && (bus.wbs_ack || to_hit);
    assign busy          = (state != ST_IDLE) || !empty;

    assign bus.wbs_adr   = adr_q;
    assign bus.wbs_wdata = wdata_q;
    assign bus.wbs_sel   = sel_q;
    assign bus.wbs_we    = we_q;
    assign bus.wbs_cyc   = act_q;
    assign bus.wbs_stb   = act_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    fsic_wb_cmd_fifo #(.pDEPTH(pCMD_DEPTH)) u_fifo (
        .coreclk  (coreclk),
        .wb_rst   (wb_rst),
        .push     (bus.cmd_valid),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty)
    );

`ifdef FSIC_WB_TIMEOUT_EN
    localparam int TW = $clog2(pTIMEOUT + 1);
    logic [TW-1:0] to_cnt;

    // The last counted cycle without ack is the abort edge; ack on that edge still wins.
    assign to_hit = (to_cnt == TW'(pTIMEOUT - 1));

    // Count REQ cycles that end without ack; restart for every new cycle.
    always_ff @(posedge coreclk or negedge wb_rst) begin
        if (!wb_rst)                               to_cnt <= '0;
        else if (state != ST_REQ)                  to_cnt <= '0;
        else if (!bus.wbs_ack)                     to_cnt <= to_cnt + TW'(1);
    end
`else
    assign to_hit = 1'b0;
`endif

    // Sequencing: IDLE pops, REQ waits for ack/abort, RSP waits for consumer, GAP spaces cycles.
    always_ff @(posedge coreclk or negedge wb_rst) begin
        if (!wb_rst) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (!empty) state <= ST_REQ;
                ST_REQ:  if (req_end) state <= ST_RSP;
                ST_RSP: begin
                    if (bus.rsp_ready) begin
                        if (pGAP == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= GW'(pGAP - 1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) state <= ST_IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Wishbone master registers: loaded on pop, held through REQ, all cleared when the cycle ends.
    always_ff @(posedge coreclk or negedge wb_rst) begin
        if (!wb_rst) begin
            adr_q   <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            act_q   <= 1'b0;
        end else if (pop) begin
            adr_q   <= head.adr;
            wdata_q <= head.wdata;
            sel_q   <= head.sel;
            we_q    <= head.we;
            act_q   <= 1'b1;
        end else if (req_end) begin
            adr_q   <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            act_q   <= 1'b0;
        end
    end

    // Response register: captured at cycle end (ack beats abort), held until consumed.
    always_ff @(posedge coreclk or negedge wb_rst) begin
        if (!wb_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (req_end) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (bus.wbs_ack && !we_q) ? bus.wbs_rdata : '0;
            rsp_err_q   <= !bus.wbs_ack;
        end else if ((state == ST_RSP) && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fsic_wb_cmd_seq.sv
// Self-checking bench for fsic_wb_cmd_seq: Wishbone slave model, response scoreboard.
// Latency: n/a.
// Backpressure: rsp_ready driven per scenario.
module tb_fsic_wb_cmd_seq;
    import fsic_wb_pkg::*;

    localparam int GAP_T = 6;
    localparam int TO_T  = 16;

    logic coreclk = 1'b0;
    logic wb_rst  = 1'b0;
    logic busy;

    fsic_wb_cmd_seq_if bus ();

    fsic_wb_cmd_seq #(.pGAP(GAP_T), .pTIMEOUT(TO_T)) dut (
        .coreclk (coreclk),
        .wb_rst  (wb_rst),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 coreclk = ~coreclk;

    int        n_tests = 0;
    int        n_fail  = 0;
    wb_cmd_t   issue_q[$];
    wb_rsp_t   exp_q[$];

    logic      slave_en  = 1'b1;
    int        ack_delay = 3;
    logic      spur_ack  = 1'b0;
    logic      expect_to = 1'b0;

    function automatic logic [31:0] slave_val(input logic [31:0] a);
        if (a == 32'h3000_0000) return 32'hA5A5_A5A5;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Wishbone slave model: checks issue order, stability, idle zeros and gap; drives ack.
    initial begin : slave
        logic    in_cyc;
        logic    seen_any;
        int      idle_cnt;
        int      stb_cnt;
        wb_cmd_t cur;
        in_cyc = 0; seen_any = 0; idle_cnt = 0; stb_cnt = 0; cur = '0;
        bus.wbs_ack = 1'b0;
        bus.wbs_rdata = '0;
        forever begin
            @(negedge coreclk);
            if (bus.wbs_stb) begin
                if (!in_cyc) begin
                    in_cyc = 1; stb_cnt = 0;
                    if (seen_any) begin
                        n_tests++;
                        if (idle_cnt < GAP_T) begin
                            n_fail++;
                            $display("FAIL wb_gap: idle cycles %0d, required >= %0d", idle_cnt, GAP_T);
                        end
                    end
                    n_tests++;
                    if (issue_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL wb_unexpected_cycle: adr=%h, no command pending", bus.wbs_adr);
                        cur = '0;
                    end else begin
                        cur = issue_q.pop_front();
                        if ({bus.wbs_adr, bus.wbs_wdata, bus.wbs_sel, bus.wbs_we} !== cur) begin
                            n_fail++;
                            $display("FAIL wb_issue: got adr=%h wdata=%h sel=%b we=%b, required adr=%h wdata=%h sel=%b we=%b",
                                     bus.wbs_adr, bus.wbs_wdata, bus.wbs_sel, bus.wbs_we, cur.adr, cur.wdata, cur.sel, cur.we);
                        end
                    end
                end else begin
                    n_tests++;
                    if ({bus.wbs_adr, bus.wbs_wdata, bus.wbs_sel, bus.wbs_we, bus.wbs_cyc} !== {cur, 1'b1}) begin
                        n_fail++;
                        $display("FAIL wb_stable: got adr=%h wdata=%h sel=%b we=%b cyc=%b, required adr=%h wdata=%h sel=%b we=%b cyc=1",
                                 bus.wbs_adr, bus.wbs_wdata, bus.wbs_sel, bus.wbs_we, bus.wbs_cyc, cur.adr, cur.wdata, cur.sel, cur.we);
                    end
                end
                stb_cnt++;
                bus.wbs_ack   = (slave_en && stb_cnt == ack_delay) || spur_ack;
                bus.wbs_rdata = bus.wbs_ack ? slave_val(bus.wbs_adr) : 32'h0;
            end else begin
                if (in_cyc) begin in_cyc = 0; seen_any = 1; idle_cnt = 0; end
                idle_cnt++;
                n_tests++;
                if ({bus.wbs_cyc, bus.wbs_adr, bus.wbs_wdata, bus.wbs_sel, bus.wbs_we} !== '0) begin
                    n_fail++;
                    $display("FAIL wb_idle_zero: cyc=%b adr=%h wdata=%h sel=%b we=%b, required all 0",
                             bus.wbs_cyc, bus.wbs_adr, bus.wbs_wdata, bus.wbs_sel, bus.wbs_we);
                end
                bus.wbs_ack   = spur_ack;
                bus.wbs_rdata = spur_ack ? 32'hDEAD_BEEF : 32'h0;
            end
        end
    end

    // Response scoreboard: every handshake must match the oldest expected response.
    initial begin : monitor
        wb_rsp_t e;
        forever begin
            @(negedge coreclk);
            if (wb_rst && bus.rsp_valid && bus.rsp_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: rdata=%h err=%b, required no response", bus.rsp_rdata, bus.rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
                        n_fail++;
                        $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                                 bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
        int      n;
        wb_cmd_t c;
        wb_rsp_t r;
        @(negedge coreclk);
        bus.cmd_adr = a; bus.cmd_wdata = d; bus.cmd_sel = s; bus.cmd_we = w;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 300) begin @(negedge coreclk); n++; end
        n_tests++;
        if (!bus.cmd_ready) begin
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
            bus.cmd_valid = 1'b0;
        end else begin
            c = '{adr: a, wdata: d, sel: s, we: w};
            issue_q.push_back(c);
            r.rdata = (w || expect_to) ? 32'h0 : slave_val(a);
            r.err   = expect_to;
            exp_q.push_back(r);
            @(posedge coreclk); #1;
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin @(negedge coreclk); #2; n++; end
        while ((busy || exp_q.size() != 0 || issue_q.size() != 0) && n < 600);
        n_tests++;
        if (busy || exp_q.size() != 0 || issue_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: busy=%b pending rsp=%0d pending issue=%0d, required 0/0/0",
                     name, busy, exp_q.size(), issue_q.size());
        end
    endtask

    task automatic set_rsp_ready(input logic v);
        @(posedge coreclk); #1;
        bus.rsp_ready = v;
    endtask

    task automatic test_reset();
        logic seen;
        repeat (3) @(negedge coreclk);
        n_tests++;
        if ({bus.wbs_cyc, bus.wbs_stb, bus.wbs_we, bus.wbs_adr, bus.wbs_wdata, bus.wbs_sel} !== '0) begin
            n_fail++;
            $display("FAIL reset_wb: cyc=%b stb=%b adr=%h, required all 0", bus.wbs_cyc, bus.wbs_stb, bus.wbs_adr);
        end
        n_tests++;
        if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, busy, bus.cmd_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_ctl: rsp_valid=%b rdata=%h err=%b busy=%b cmd_ready=%b, required 0/0/0/0/1",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, busy, bus.cmd_ready);
        end
        wb_rst = 1'b1;
        // Reset in the middle of a cycle the slave never acknowledges.
        slave_en = 1'b0;
        set_rsp_ready(1'b1);
        send(32'h3000_0004, 32'h0, 4'hF, 1'b0);
        repeat (4) @(negedge coreclk);
        n_tests++;
        if (bus.wbs_stb !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midreq_pre: stb=%b, required 1", bus.wbs_stb);
        end
        #2 wb_rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.wbs_cyc, bus.wbs_stb, bus.wbs_adr, bus.rsp_valid, busy, bus.cmd_ready} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_midreq: cyc=%b stb=%b adr=%h rsp_valid=%b busy=%b cmd_ready=%b, required 0/0/0/0/0/1",
                     bus.wbs_cyc, bus.wbs_stb, bus.wbs_adr, bus.rsp_valid, busy, bus.cmd_ready);
        end
        exp_q.delete();
        issue_q.delete();
        @(negedge coreclk);
        wb_rst = 1'b1;
        slave_en = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge coreclk);
            if (bus.rsp_valid || bus.wbs_stb) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_rsp: activity after release=%b, required 0", seen);
        end
    endtask

    task automatic test_write();
        ack_delay = 3;
        wait_idle("write_pre");
        send(32'h3000_3000, 32'h0000_0001, 4'b0001, 1'b1);
        @(negedge coreclk);
        n_tests++;
        if (bus.wbs_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL write_latency_early: cyc=%b one cycle after accept, required 0", bus.wbs_cyc);
        end
        @(negedge coreclk);
        n_tests++;
        if (bus.wbs_cyc !== 1'b1 || bus.wbs_stb !== 1'b1) begin
            n_fail++;
            $display("FAIL write_latency: cyc=%b stb=%b two cycles after accept, required 1/1", bus.wbs_cyc, bus.wbs_stb);
        end
        wait_idle("write");
        ack_delay = 1;
        send(32'h3000_3004, 32'h1234_5678, 4'b1111, 1'b1);
        wait_idle("write_full");
    endtask

    task automatic test_read();
        int   n;
        ack_delay = 2;
        send(32'h3000_0000, 32'h0, 4'hF, 1'b0);
        wait_idle("read");
        // Response held while the consumer stalls.
        set_rsp_ready(1'b0);
        send(32'h3000_1234, 32'h0, 4'hF, 1'b0);
        n = 0;
        do begin @(negedge coreclk); n++; end while (!bus.rsp_valid && n < 50);
        repeat (3) begin
            @(negedge coreclk);
            n_tests++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== slave_val(32'h3000_1234)) begin
                n_fail++;
                $display("FAIL read_hold: rsp_valid=%b rdata=%h, required 1/%h",
                         bus.rsp_valid, bus.rsp_rdata, slave_val(32'h3000_1234));
            end
        end
        set_rsp_ready(1'b1);
        wait_idle("read_hold");
    endtask

    task automatic test_back_to_back();
        logic rdy_seen;
        ack_delay = 3;
        set_rsp_ready(1'b0);
        wait_idle("b2b_pre");
        send(32'h3000_3000, 32'h0000_0001, 4'b0001, 1'b1);
        send(32'h3000_3000, 32'h0000_0003, 4'b0001, 1'b1);
        send(32'h3000_2000, 32'hA5A5_A5A5, 4'b1111, 1'b1);
        send(32'h3000_0000, 32'h0, 4'b1111, 1'b0);
        send(32'h3000_2004, 32'h0, 4'b1111, 1'b0);
        @(negedge coreclk);
        n_tests++;
        if (bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: cmd_ready=%b after 5th accept, required 0", bus.cmd_ready);
        end
        rdy_seen = 1'b0;
        repeat (10) begin
            @(negedge coreclk);
            if (bus.cmd_ready) rdy_seen = 1'b1;
        end
        n_tests++;
        if (rdy_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stall: cmd_ready rose while responses blocked=%b, required 0", rdy_seen);
        end
        set_rsp_ready(1'b1);
        send(32'h3000_5000, 32'h0000_0007, 4'b0011, 1'b1);
        wait_idle("b2b");
    endtask

`ifdef FSIC_WB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int cnt;
        @(posedge coreclk); #1;
        slave_en  = 1'b0;
        expect_to = 1'b1;
        send(32'h3000_0008, 32'h0, 4'hF, 1'b0);
        n = 0;
        @(negedge coreclk);
        while (!bus.wbs_stb && n < 20) begin @(negedge coreclk); n++; end
        cnt = 0;
        while (bus.wbs_stb && cnt < 100) begin cnt++; @(negedge coreclk); end
        n_tests++;
        if (cnt != TO_T) begin
            n_fail++;
            $display("FAIL timeout_len: stb high %0d cycles, required %0d", cnt, TO_T);
        end
        @(posedge coreclk); #1;
        expect_to = 1'b0;
        slave_en  = 1'b1;
        wait_idle("timeout");
    endtask
`endif

    task automatic check_quiet(input string name);
        logic seen;
        seen = 1'b0;
        repeat (15) begin
            @(negedge coreclk);
            if (bus.rsp_valid || bus.wbs_stb) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: activity after spurious ack=%b, required 0", name, seen);
        end
    endtask

    task automatic test_spurious();
        int n;
        ack_delay = 2;
        send(32'h3000_3008, 32'h0000_00FF, 4'b0001, 1'b1);
        n = 0;
        do begin @(negedge coreclk); #2; n++; end while (exp_q.size() != 0 && n < 100);
        @(posedge coreclk); #1;
        spur_ack = 1'b1;
        @(posedge coreclk); #1;
        spur_ack = 1'b0;
        check_quiet("spurious_gap");
        wait_idle("spurious_gap");
        @(posedge coreclk); #1;
        spur_ack = 1'b1;
        @(posedge coreclk); #1;
        spur_ack = 1'b0;
        check_quiet("spurious_idle");
        send(32'h3000_0000, 32'h0, 4'hF, 1'b0);
        wait_idle("spurious_next");
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.cmd_valid = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_wdata = '0;
        bus.cmd_sel   = '0;
        bus.cmd_we    = 1'b0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
`ifdef FSIC_WB_TIMEOUT_EN
        test_timeout();
`endif
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
